// File: rtl/risc_mem_pkg.sv
// Shared definitions for the 8-bit RISC data-memory port: widths and LSU state encoding.
// The VF_* states exist only when LSU_WRITE_VERIFY_EN is defined.
package risc_mem_pkg;

    localparam int DATA_WIDTH = 8;
    localparam int ADDR_WIDTH = 8;

    typedef logic [DATA_WIDTH-1:0] data_t;
    typedef logic [ADDR_WIDTH-1:0] addr_t;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_WAIT = 3'd1,
        RD_CAPT = 3'd2,
`ifdef LSU_WRITE_VERIFY_EN
        WR      = 3'd3,
        VF_WAIT = 3'd4,
        VF_CMP  = 3'd5
`else
        WR      = 3'd3
`endif
    } lsu_state_t;

    function automatic logic is_idle(input lsu_state_t s);
        return s == IDLE;
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Request/response handshake and data-memory bus between datapath, LSU and memory.
// slave = the load/store unit, master = its environment (datapath plus memory).
interface load_store_unit_if
    import risc_mem_pkg::*;
#(
    parameter int data_width    = DATA_WIDTH,
    parameter int address_width = ADDR_WIDTH
);

    logic                     req_valid;
    logic                     req_ready;
    logic                     req_write;
    logic [address_width-1:0] req_addr;
    logic [data_width-1:0]    req_wdata;

    logic                     resp_valid;
    logic [data_width-1:0]    resp_rdata;
    logic                     resp_err;

    logic                     mem_rd_wr;
    logic [address_width-1:0] mem_address;
    logic [data_width-1:0]    mem_data_in;
    logic [data_width-1:0]    mem_data_bus;

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata,
        output req_ready,
        output resp_valid, resp_rdata, resp_err,
        output mem_rd_wr, mem_address, mem_data_in,
        input  mem_data_bus
    );

    modport master (
        output req_valid, req_write, req_addr, req_wdata,
        input  req_ready,
        input  resp_valid, resp_rdata, resp_err,
        input  mem_rd_wr, mem_address, mem_data_in,
        output mem_data_bus
    );

endinterface

// File: rtl/load_store_unit.sv
// Initiator for the 256x8 data memory: one-cycle store pulses, two-cycle loads.
// Optional store read-back check enabled by LSU_WRITE_VERIFY_EN.
module load_store_unit
    import risc_mem_pkg::*;
#(
    parameter int data_width    = DATA_WIDTH,
    parameter int address_width = ADDR_WIDTH
)
(
    input logic              clock,
    input logic              reset,
    load_store_unit_if.slave lsu
);

    lsu_state_t               state;
    lsu_state_t               state_next;
    logic                     rd_wr_next;
    logic [address_width-1:0] address_next;
    logic [data_width-1:0]    wdata_next;
    logic                     valid_next;
    logic [data_width-1:0]    rdata_next;
`ifdef LSU_WRITE_VERIFY_EN
    logic                     err_next;
`endif

    assign lsu.req_ready = is_idle(state);

    // mem_rd_wr defaults high: the memory writes on every cycle it sees 0.
    always_comb begin
        state_next   = state;
        rd_wr_next   = 1'b1;
        address_next = lsu.mem_address;
        wdata_next   = lsu.mem_data_in;
        valid_next   = 1'b0;
        rdata_next   = lsu.resp_rdata;
`ifdef LSU_WRITE_VERIFY_EN
        err_next     = lsu.resp_err;
`endif
        unique case (state)
            IDLE: begin
                if (lsu.req_valid) begin
                    address_next = lsu.req_addr;
                    if (lsu.req_write) begin
                        wdata_next = lsu.req_wdata;
                        rd_wr_next = 1'b0;
                        state_next = WR;
                    end else begin
                        state_next = RD_WAIT;
                    end
                end
            end
            RD_WAIT: begin
                state_next = RD_CAPT;
            end
            RD_CAPT: begin
                rdata_next = lsu.mem_data_bus;
                valid_next = 1'b1;
`ifdef LSU_WRITE_VERIFY_EN
                err_next   = 1'b0;
`endif
                state_next = IDLE;
            end
            WR: begin
`ifdef LSU_WRITE_VERIFY_EN
                state_next = VF_WAIT;
`else
                valid_next = 1'b1;
                state_next = IDLE;
`endif
            end
`ifdef LSU_WRITE_VERIFY_EN
            VF_WAIT: begin
                state_next = VF_CMP;
            end
            // data_bus now holds the row read back on the previous edge
            VF_CMP: begin
                valid_next = 1'b1;
                err_next   = (lsu.mem_data_bus != lsu.mem_data_in);
                state_next = IDLE;
            end
`endif
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state           <= IDLE;
            lsu.mem_rd_wr   <= 1'b1;
            lsu.mem_address <= '0;
            lsu.mem_data_in <= '0;
            lsu.resp_valid  <= 1'b0;
            lsu.resp_rdata  <= '0;
        end else begin
            state           <= state_next;
            lsu.mem_rd_wr   <= rd_wr_next;
            lsu.mem_address <= address_next;
            lsu.mem_data_in <= wdata_next;
            lsu.resp_valid  <= valid_next;
            lsu.resp_rdata  <= rdata_next;
        end
    end

`ifdef LSU_WRITE_VERIFY_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            lsu.resp_err <= 1'b0;
        end else begin
            lsu.resp_err <= err_next;
        end
    end
`else
    assign lsu.resp_err = 1'b0;
`endif

endmodule
